// File: rtl/gpu_column_fetcher_if.sv
// Memory read port between the column fetcher and the read arbiter.
// master: mem_rd_en/mem_addr out, mem_grant/mem_rd_data in.
interface gpu_column_fetcher_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_grant;
    logic [DATA_W-1:0] mem_rd_data;

    modport master (
        output mem_rd_en,
        output mem_addr,
        input  mem_grant,
        input  mem_rd_data
    );

    modport slave (
        input  mem_rd_en,
        input  mem_addr,
        output mem_grant,
        output mem_rd_data
    );
endinterface

// File: rtl/gpu_column_fetcher.sv
// Per-frame column fetcher: reads NUM_FIELDS words per column from the
// selected memory bank into the back half of a ping-pong line buffer.
// Ports: clk, clr (async active-low), frame_start, mem (read port),
// col_index/col_data (renderer side, 1-cycle latency), front_valid,
// busy, bank_sel, overrun_count, fetch_cycles.
// Optional macro GPU_FETCH_STATS_EN builds the overrun/duration counters;
// without it both outputs are tied to zero.
module gpu_column_fetcher #(
    parameter int              NUM_COLUMNS  = 320,
    parameter int              NUM_FIELDS   = 2,
    parameter int              DATA_W       = 16,
    parameter int              ADDR_W       = 16,
    parameter logic [ADDR_W-1:0] BANK0_BASE   = 16'd63488,
    parameter logic [ADDR_W-1:0] BANK1_BASE   = 16'd64512,
    parameter logic [ADDR_W-1:0] FIELD_STRIDE = 16'd512,
    parameter int              READ_LATENCY = 1,
    localparam int             CW = (NUM_COLUMNS > 1) ? $clog2(NUM_COLUMNS) : 1,
    localparam int             FW = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1,
    localparam int             LW = NUM_FIELDS * DATA_W
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 frame_start,
    gpu_column_fetcher_if.master mem,
    input  logic [CW-1:0]        col_index,
    output logic [LW-1:0]        col_data,
    output logic                 front_valid,
    output logic                 busy,
    output logic                 bank_sel,
    output logic [15:0]          overrun_count,
    output logic [15:0]          fetch_cycles
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_t;

    state_t          state;
    logic            front;
    logic            back_ready;
    logic [CW-1:0]   col;
    logic [FW-1:0]   fld;
    logic [CW-1:0]   ncol;
    logic [FW-1:0]   nfld;
    logic            last_col;
    logic            last_fld;
    logic            acc;
    logic            pipe_tail_busy;
    logic            drain_done;

    logic            pv [READ_LATENCY];
    logic [CW-1:0]   pc [READ_LATENCY];
    logic [FW-1:0]   pf [READ_LATENCY];

    logic [LW-1:0]   line_mem [2][NUM_COLUMNS];

    function automatic logic [ADDR_W-1:0] addr_of(
        input logic          bank,
        input logic [CW-1:0] c,
        input logic [FW-1:0] f
    );
        logic [ADDR_W-1:0] base;
        base = bank ? BANK1_BASE : BANK0_BASE;
        return base + ADDR_W'(f) * FIELD_STRIDE + ADDR_W'(c);
    endfunction

    assign busy = (state != IDLE);
    assign acc  = (state == FETCH) && mem.mem_grant;

    always_comb begin
        last_col = (col == CW'(NUM_COLUMNS - 1));
        last_fld = (fld == FW'(NUM_FIELDS - 1));
        nfld     = last_fld ? '0 : fld + 1'b1;
        ncol     = last_fld ? col + 1'b1 : col;
    end

    // True while any request will still be in flight after this edge;
    // the final stage is being written this cycle and does not count.
    always_comb begin
        pipe_tail_busy = 1'b0;
        for (int i = 0; i < READ_LATENCY - 1; i++) begin
            pipe_tail_busy = pipe_tail_busy | pv[i];
        end
    end

    assign drain_done = (state == DRAIN) && !pipe_tail_busy;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state         <= IDLE;
            mem.mem_rd_en <= 1'b0;
            mem.mem_addr  <= '0;
            front         <= 1'b0;
            front_valid   <= 1'b0;
            bank_sel      <= 1'b1;
            back_ready    <= 1'b0;
            col           <= '0;
            fld           <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (frame_start && (back_ready || !front_valid)) begin
                        if (back_ready) begin
                            front <= ~front;
                        end
                        front_valid   <= back_ready | front_valid;
                        bank_sel      <= ~bank_sel;
                        back_ready    <= 1'b0;
                        col           <= '0;
                        fld           <= '0;
                        mem.mem_rd_en <= 1'b1;
                        mem.mem_addr  <= addr_of(~bank_sel, '0, '0);
                        state         <= FETCH;
                    end
                end
                FETCH: begin
                    if (mem.mem_grant) begin
                        if (last_col && last_fld) begin
                            mem.mem_rd_en <= 1'b0;
                            state         <= DRAIN;
                        end else begin
                            col          <= ncol;
                            fld          <= nfld;
                            mem.mem_addr <= addr_of(bank_sel, ncol, nfld);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        back_ready <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Return tags; clearing the valid bits on reset drops late data.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                pv[i] <= 1'b0;
                pc[i] <= '0;
                pf[i] <= '0;
            end
        end else begin
            pv[0] <= acc;
            pc[0] <= col;
            pf[0] <= fld;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pv[i] <= pv[i-1];
                pc[i] <= pc[i-1];
                pf[i] <= pf[i-1];
            end
        end
    end

    // Returned words only ever land in the back half.
    always_ff @(posedge clk) begin
        if (pv[READ_LATENCY-1]) begin
            line_mem[~front][pc[READ_LATENCY-1]][pf[READ_LATENCY-1]*DATA_W +: DATA_W]
                <= mem.mem_rd_data;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            col_data <= '0;
        end else if (int'(col_index) < NUM_COLUMNS) begin
            col_data <= line_mem[front][col_index];
        end else begin
            col_data <= '0;
        end
    end

`ifdef GPU_FETCH_STATS_EN
    logic [15:0] ovr_q;
    logic [15:0] cyc_q;
    logic [15:0] last_q;
    logic [15:0] cyc_inc;

    assign cyc_inc = (cyc_q == 16'hFFFF) ? cyc_q : cyc_q + 16'd1;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            ovr_q  <= '0;
            cyc_q  <= '0;
            last_q <= '0;
        end else begin
            if (frame_start && busy && ovr_q != 16'hFFFF) begin
                ovr_q <= ovr_q + 16'd1;
            end
            if (!busy) begin
                cyc_q <= '0;
            end else begin
                cyc_q <= cyc_inc;
            end
            if (drain_done) begin
                last_q <= cyc_inc;
            end
        end
    end

    assign overrun_count = ovr_q;
    assign fetch_cycles  = last_q;
`else
    assign overrun_count = '0;
    assign fetch_cycles  = '0;
`endif

endmodule

// File: tb/tb_gpu_column_fetcher.sv
// Self-checking bench for gpu_column_fetcher: request scoreboard,
// latency-2 memory model returning addr^5A5A, line-buffer readback.
module tb_gpu_column_fetcher;

    localparam int          NC  = 4;
    localparam int          NF  = 2;
    localparam int          DW  = 16;
    localparam int          AW  = 16;
    localparam int          L   = 2;
    localparam logic [15:0] B0  = 16'd63488;
    localparam logic [15:0] B1  = 16'd64512;
    localparam logic [15:0] STR = 16'd512;
    localparam logic [15:0] KEY = 16'h5A5A;

    logic             clk = 1'b0;
    logic             clr = 1'b0;
    logic             frame_start = 1'b0;
    logic [1:0]       col_index = '0;
    logic [NF*DW-1:0] col_data;
    logic             front_valid;
    logic             busy;
    logic             bank_sel;
    logic [15:0]      overrun_count;
    logic [15:0]      fetch_cycles;

    int n_chk = 0;
    int n_err = 0;

    gpu_column_fetcher_if #(.ADDR_W(AW), .DATA_W(DW)) mem ();

    gpu_column_fetcher #(
        .NUM_COLUMNS(NC), .NUM_FIELDS(NF), .DATA_W(DW), .ADDR_W(AW),
        .BANK0_BASE(B0), .BANK1_BASE(B1), .FIELD_STRIDE(STR),
        .READ_LATENCY(L)
    ) dut (
        .clk(clk), .clr(clr), .frame_start(frame_start), .mem(mem),
        .col_index(col_index), .col_data(col_data),
        .front_valid(front_valid), .busy(busy), .bank_sel(bank_sel),
        .overrun_count(overrun_count), .fetch_cycles(fetch_cycles)
    );

    always #5 clk = ~clk;

    logic        mv [L];
    logic [15:0] ma [L];

    initial begin
        for (int i = 0; i < L; i++) begin
            mv[i] = 1'b0;
            ma[i] = '0;
        end
    end

    always @(posedge clk) begin
        mv[0] <= mem.mem_rd_en & mem.mem_grant;
        ma[0] <= mem.mem_addr;
        for (int i = 1; i < L; i++) begin
            mv[i] <= mv[i-1];
            ma[i] <= ma[i-1];
        end
    end

    assign mem.mem_rd_data = mv[L-1] ? (ma[L-1] ^ KEY) : '0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] eaddr(input bit b, input int c,
                                          input int f);
        return (b ? B1 : B0) + 16'(f) * STR + 16'(c);
    endfunction

    function automatic logic [NF*DW-1:0] ecol(input bit b, input int c);
        logic [NF*DW-1:0] r;
        r = '0;
        for (int f = 0; f < NF; f++) begin
            r[f*DW +: DW] = eaddr(b, c, f) ^ KEY;
        end
        return r;
    endfunction

    logic [15:0] req_q [$];

    always @(negedge clk) begin
        if (clr && mem.mem_rd_en && mem.mem_grant) begin
            check("req_expected", 64'(req_q.size() != 0), 64'd1);
            if (req_q.size() != 0) begin
                check("req_addr", 64'(mem.mem_addr), 64'(req_q.pop_front()));
            end
        end
    end

    bit exp_bank   = 1'b1;
    bit back_bank  = 1'b0;
    bit front_bank = 1'b0;
    bit tb_fv      = 1'b0;
    bit tb_br      = 1'b0;
    int exp_ovr    = 0;

    task automatic run_frame(input bit toggle, input bit ovr,
                             input int exp_len);
        int  len;
        bit  done;
        mem.mem_grant = 1'b1;
        frame_start   = 1'b1;
        if (tb_br || !tb_fv) begin
            if (tb_br) front_bank = back_bank;
            tb_fv     = tb_fv | tb_br;
            exp_bank  = ~exp_bank;
            back_bank = exp_bank;
            tb_br     = 1'b0;
            for (int c = 0; c < NC; c++) begin
                for (int f = 0; f < NF; f++) begin
                    req_q.push_back(eaddr(exp_bank, c, f));
                end
            end
        end
        @(posedge clk); #1;
        frame_start = 1'b0;
        check("busy_rise", 64'(busy), 64'd1);
        check("front_valid", 64'(front_valid), 64'(tb_fv));
        check("bank_sel", 64'(bank_sel), 64'(exp_bank));
        done = 1'b0;
        len  = 0;
        for (int n = 1; n <= 100 && !done; n++) begin
            @(posedge clk); #1;
            if (toggle) mem.mem_grant = ~mem.mem_grant;
            frame_start = ovr && (n == 2 || n == 4);
            if (ovr && (n == 2 || n == 4)) exp_ovr++;
            if (!busy) begin
                done = 1'b1;
                len  = n;
            end
        end
        frame_start   = 1'b0;
        mem.mem_grant = 1'b1;
        check("fetch_done", 64'(done), 64'd1);
        check("fetch_len", 64'(len), 64'(exp_len));
        check("rd_en_low", 64'(mem.mem_rd_en), 64'd0);
        check("req_left", 64'(req_q.size()), 64'd0);
`ifdef GPU_FETCH_STATS_EN
        check("fetch_cycles", 64'(fetch_cycles), 64'(exp_len));
        check("overrun", 64'(overrun_count), 64'(exp_ovr));
`else
        check("fetch_cycles", 64'(fetch_cycles), 64'd0);
        check("overrun", 64'(overrun_count), 64'd0);
`endif
        tb_br = 1'b1;
    endtask

    task automatic read_cols();
        for (int c = 0; c < NC; c++) begin
            col_index = 2'(c);
            @(posedge clk); #1;
            check("col_data", 64'(col_data), 64'(ecol(front_bank, c)));
        end
    endtask

    task automatic check_reset();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rd_en", 64'(mem.mem_rd_en), 64'd0);
        check("rst_addr", 64'(mem.mem_addr), 64'd0);
        check("rst_fv", 64'(front_valid), 64'd0);
        check("rst_bank", 64'(bank_sel), 64'd1);
        check("rst_col_data", 64'(col_data), 64'd0);
        check("rst_ovr", 64'(overrun_count), 64'd0);
        check("rst_cycles", 64'(fetch_cycles), 64'd0);
    endtask

    initial begin
        mem.mem_grant = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset();
        clr = 1'b1;
        @(posedge clk); #1;

        run_frame(1'b0, 1'b0, 10);
        check("fv_after_first", 64'(front_valid), 64'd0);

        run_frame(1'b1, 1'b0, 17);
        read_cols();

        run_frame(1'b0, 1'b1, 10);
        col_index = 2'd2;
        @(posedge clk); #1;
        check("front_kept", 64'(col_data), 64'(ecol(front_bank, 2)));

        run_frame(1'b0, 1'b0, 10);
        read_cols();

        // Reset with two reads outstanding.
        mem.mem_grant = 1'b1;
        frame_start   = 1'b1;
        exp_bank      = ~exp_bank;
        for (int c = 0; c < NC; c++) begin
            for (int f = 0; f < NF; f++) begin
                req_q.push_back(eaddr(exp_bank, c, f));
            end
        end
        @(posedge clk); #1;
        frame_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        clr = 1'b0;
        #1;
        check_reset();
        req_q.delete();
        exp_bank = 1'b1;
        tb_fv    = 1'b0;
        tb_br    = 1'b0;
        exp_ovr  = 0;
        repeat (3) @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk); #1;

        run_frame(1'b0, 1'b0, 10);
        check("fv_after_reset", 64'(front_valid), 64'd0);
        run_frame(1'b1, 1'b0, 17);
        read_cols();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
